// File: rtl/m_uinx_pkg.sv
// Shared types and default constants for the microcode index sequencer.
// Optional irq dispatch is selected with MIDGETV_UINX_IRQ_EN.
package m_uinx_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  localparam logic [7:0] DEF_RESET_VEC     = 8'h01;
  localparam logic [7:0] DEF_DISPATCH_CODE = 8'hFF;
  localparam logic [7:0] DEF_ILLEGAL_ENTRY = 8'hFE;
  localparam logic [7:0] DEF_IRQ_ENTRY     = 8'hFD;

  function automatic logic [7:0] br_target(input logic [7:0] rinx);
    return rinx | 8'h01;
  endfunction

endpackage

// File: rtl/m_uinx_seq_if.sv
// Sequencer control bundle: microword/bus/irq controls in, store index and status out.
// slave is the sequencer side; master is the microword/bus side that drives it.
interface m_uinx_seq_if;
  logic [7:0] rinx;
  logic       use_brcond;
  logic       brcond;
  logic [4:0] instr_opc;
  logic [2:0] instr_f3;
  logic       shcnt_load;
  logic [4:0] shamt;
  logic       stb_pending;
  logic       ack_i;
  logic       irq_pending;
  logic       irq_enable;
  logic [7:0] minx;
  logic       progress_ucode;
  logic       busy_shift;
  logic       dispatching;

  modport slave (
    input  rinx, use_brcond, brcond, instr_opc, instr_f3, shcnt_load, shamt,
           stb_pending, ack_i, irq_pending, irq_enable,
    output minx, progress_ucode, busy_shift, dispatching
  );

  modport master (
    output rinx, use_brcond, brcond, instr_opc, instr_f3, shcnt_load, shamt,
           stb_pending, ack_i, irq_pending, irq_enable,
    input  minx, progress_ucode, busy_shift, dispatching
  );
endinterface

// File: rtl/m_uinx_dispatch.sv
// Combinational dispatch map {opc,f3,irq_taken} -> microcode entry; zero latency.
// The illegal entry covers the one instruction index that collides with the dispatch code.
module m_uinx_dispatch
  import m_uinx_pkg::*;
#(
  parameter logic [7:0] DISPATCH_CODE = DEF_DISPATCH_CODE,
  parameter logic [7:0] ILLEGAL_ENTRY = DEF_ILLEGAL_ENTRY,
  parameter logic [7:0] IRQ_ENTRY     = DEF_IRQ_ENTRY
) (
  input  logic [4:0] opc_i,
  input  logic [2:0] f3_i,
  input  logic       irq_taken_i,
  output logic [7:0] minx_o
);

  logic [7:0] di;
  assign di = {opc_i, f3_i};

  always_comb begin
    if (irq_taken_i)               minx_o = IRQ_ENTRY;
    else if (di == DISPATCH_CODE)  minx_o = ILLEGAL_ENTRY;
    else                           minx_o = di;
  end

endmodule

// File: rtl/m_uinx_seq.sv
// Microcode sequencer: combinational next index to the store, store freeze on reset/shift/bus wait.
// Irq entry at dispatch only when MIDGETV_UINX_IRQ_EN is defined; ports exist in both builds.
module m_uinx_seq
  import m_uinx_pkg::*;
#(
  parameter logic [7:0] RESET_VEC     = DEF_RESET_VEC,
  parameter int          RESET_CYCLES  = 4,
  parameter logic [7:0] DISPATCH_CODE = DEF_DISPATCH_CODE,
  parameter logic [7:0] ILLEGAL_ENTRY = DEF_ILLEGAL_ENTRY,
  parameter logic [7:0] IRQ_ENTRY     = DEF_IRQ_ENTRY
) (
  input  logic         clk,
  input  logic         rst,
  m_uinx_seq_if.slave  sq
);

  localparam logic [4:0] CNT_RST = 5'(RESET_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cur_minx_q, cur_minx_d;
  logic [4:0] cnt_q, cnt_d;

  logic [7:0] minx_c;
  logic       prog_c, busy_c, disp_c;
  logic       irq_taken;
  logic [7:0] disp_minx;

`ifdef MIDGETV_UINX_IRQ_EN
  assign irq_taken = sq.irq_pending & sq.irq_enable;
`else
  assign irq_taken = 1'b0;
`endif

  m_uinx_dispatch #(
    .DISPATCH_CODE (DISPATCH_CODE),
    .ILLEGAL_ENTRY (ILLEGAL_ENTRY),
    .IRQ_ENTRY     (IRQ_ENTRY)
  ) u_dispatch (
    .opc_i       (sq.instr_opc),
    .f3_i        (sq.instr_f3),
    .irq_taken_i (irq_taken),
    .minx_o      (disp_minx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    minx_c  = cur_minx_q;
    prog_c  = 1'b0;
    busy_c  = 1'b0;
    disp_c  = 1'b0;
    unique case (state_q)
      S_RESET: begin
        minx_c = RESET_VEC;
        prog_c = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_RUN: begin
        if (sq.stb_pending && !sq.ack_i) begin
          prog_c = 1'b0;
        end else if (sq.shcnt_load && (sq.shamt != 5'd0)) begin
          // Load cycle counts toward the hold; a 1-cycle shift never enters S_SHIFT.
          busy_c = 1'b1;
          cnt_d  = sq.shamt - 5'd1;
          if (sq.shamt != 5'd1) state_d = S_SHIFT;
        end else if (sq.rinx == DISPATCH_CODE) begin
          prog_c = 1'b1;
          disp_c = 1'b1;
          minx_c = disp_minx;
        end else if (sq.use_brcond && sq.brcond) begin
          prog_c = 1'b1;
          minx_c = br_target(sq.rinx);
        end else begin
          prog_c = 1'b1;
          minx_c = sq.rinx;
        end
      end
      S_SHIFT: begin
        busy_c = 1'b1;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_d == 5'd0) state_d = S_RUN;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = CNT_RST;
      end
    endcase
    cur_minx_d = prog_c ? minx_c : cur_minx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      cnt_q      <= CNT_RST;
      cur_minx_q <= RESET_VEC;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_minx_q <= cur_minx_d;
    end
  end

  assign sq.minx           = minx_c;
  assign sq.progress_ucode = prog_c;
  assign sq.busy_shift     = busy_c;
  assign sq.dispatching    = disp_c;

endmodule

// File: tb/tb_m_uinx_seq.sv
// Directed bench for m_uinx_seq; irq expectations follow MIDGETV_UINX_IRQ_EN.
module tb_m_uinx_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  m_uinx_seq_if u_if();

  m_uinx_seq u_dut (
    .clk (clk),
    .rst (rst),
    .sq  (u_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.rinx        = 8'h00;
    u_if.use_brcond  = 1'b0;
    u_if.brcond      = 1'b0;
    u_if.instr_opc   = 5'd0;
    u_if.instr_f3    = 3'd0;
    u_if.shcnt_load  = 1'b0;
    u_if.shamt       = 5'd0;
    u_if.stb_pending = 1'b0;
    u_if.ack_i       = 1'b0;
    u_if.irq_pending = 1'b0;
    u_if.irq_enable  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    u_if.rinx = 8'h40;
    rst = 1'b1;
    step();
    step();
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h01 || u_if.progress_ucode !== 1'b1 ||
        u_if.busy_shift !== 1'b0 || u_if.dispatching !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got minx=%h prog=%b busy=%b disp=%b want 01 1 0 0",
               u_if.minx, u_if.progress_ucode, u_if.busy_shift, u_if.dispatching);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_cmp++;
      if (u_if.minx !== 8'h01 || u_if.progress_ucode !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_seq cycle %0d got minx=%h prog=%b want 01 1",
                 i, u_if.minx, u_if.progress_ucode);
      end
      step();
    end
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h40 || u_if.progress_ucode !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_exit got minx=%h prog=%b want 40 1", u_if.minx, u_if.progress_ucode);
    end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    u_if.rinx = 8'h20; u_if.use_brcond = 1'b1; u_if.brcond = 1'b1;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h21 || u_if.dispatching !== 1'b0) begin
      n_bad++;
      $display("FAIL branch_taken got minx=%h disp=%b want 21 0", u_if.minx, u_if.dispatching);
    end
    step();
    u_if.brcond = 1'b0;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h20) begin
      n_bad++;
      $display("FAIL branch_not_taken got minx=%h want 20", u_if.minx);
    end
    step();
    u_if.use_brcond = 1'b0; u_if.brcond = 1'b1; u_if.rinx = 8'h36;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h36) begin
      n_bad++;
      $display("FAIL branch_disabled got minx=%h want 36", u_if.minx);
    end
    step();
  endtask

  task automatic test_dispatch();
    logic [7:0] exp_irq;
    clear_inputs();
    u_if.rinx = 8'hFF; u_if.instr_opc = 5'b00100; u_if.instr_f3 = 3'b001;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h21 || u_if.dispatching !== 1'b1 || u_if.progress_ucode !== 1'b1) begin
      n_bad++;
      $display("FAIL dispatch_instr got minx=%h disp=%b prog=%b want 21 1 1",
               u_if.minx, u_if.dispatching, u_if.progress_ucode);
    end
    step();
    u_if.instr_opc = 5'b11111; u_if.instr_f3 = 3'b111;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'hFE || u_if.dispatching !== 1'b1) begin
      n_bad++;
      $display("FAIL dispatch_illegal got minx=%h disp=%b want FE 1", u_if.minx, u_if.dispatching);
    end
    step();
    // Branch enable must not alter a dispatch target.
    u_if.instr_opc = 5'b01100; u_if.instr_f3 = 3'b000;
    u_if.use_brcond = 1'b1; u_if.brcond = 1'b1;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h60) begin
      n_bad++;
      $display("FAIL dispatch_over_branch got minx=%h want 60", u_if.minx);
    end
    step();
    u_if.use_brcond = 1'b0; u_if.brcond = 1'b0;
    u_if.irq_pending = 1'b1; u_if.irq_enable = 1'b0;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h60) begin
      n_bad++;
      $display("FAIL dispatch_irq_masked got minx=%h want 60", u_if.minx);
    end
    step();
    u_if.irq_enable = 1'b1;
`ifdef MIDGETV_UINX_IRQ_EN
    exp_irq = 8'hFD;
`else
    exp_irq = 8'h60;
`endif
    #2;
    n_cmp++;
    if (u_if.minx !== exp_irq || u_if.dispatching !== 1'b1) begin
      n_bad++;
      $display("FAIL dispatch_irq got minx=%h disp=%b want %h 1", u_if.minx, u_if.dispatching, exp_irq);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_shift();
    clear_inputs();
    u_if.rinx = 8'h30;
    step();
    u_if.rinx = 8'h50; u_if.shcnt_load = 1'b1; u_if.shamt = 5'd5;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_cmp++;
      if (u_if.progress_ucode !== 1'b0 || u_if.busy_shift !== 1'b1 || u_if.minx !== 8'h30) begin
        n_bad++;
        $display("FAIL shift5_hold cycle %0d got prog=%b busy=%b minx=%h want 0 1 30",
                 i, u_if.progress_ucode, u_if.busy_shift, u_if.minx);
      end
      step();
      u_if.shcnt_load = 1'b0;
    end
    #2;
    n_cmp++;
    if (u_if.progress_ucode !== 1'b1 || u_if.busy_shift !== 1'b0 || u_if.minx !== 8'h50) begin
      n_bad++;
      $display("FAIL shift5_release got prog=%b busy=%b minx=%h want 1 0 50",
               u_if.progress_ucode, u_if.busy_shift, u_if.minx);
    end
    step();
    u_if.rinx = 8'h44; u_if.shcnt_load = 1'b1; u_if.shamt = 5'd0;
    #2;
    n_cmp++;
    if (u_if.progress_ucode !== 1'b1 || u_if.busy_shift !== 1'b0 || u_if.minx !== 8'h44) begin
      n_bad++;
      $display("FAIL shift0_nostall got prog=%b busy=%b minx=%h want 1 0 44",
               u_if.progress_ucode, u_if.busy_shift, u_if.minx);
    end
    step();
    u_if.rinx = 8'h58; u_if.shamt = 5'd1;
    #2;
    n_cmp++;
    if (u_if.progress_ucode !== 1'b0 || u_if.busy_shift !== 1'b1 || u_if.minx !== 8'h44) begin
      n_bad++;
      $display("FAIL shift1_hold got prog=%b busy=%b minx=%h want 0 1 44",
               u_if.progress_ucode, u_if.busy_shift, u_if.minx);
    end
    step();
    u_if.shcnt_load = 1'b0;
    #2;
    n_cmp++;
    if (u_if.progress_ucode !== 1'b1 || u_if.busy_shift !== 1'b0 || u_if.minx !== 8'h58) begin
      n_bad++;
      $display("FAIL shift1_release got prog=%b busy=%b minx=%h want 1 0 58",
               u_if.progress_ucode, u_if.busy_shift, u_if.minx);
    end
    step();
  endtask

  task automatic test_bus_wait();
    clear_inputs();
    u_if.rinx = 8'h10;
    step();
    u_if.rinx = 8'h70; u_if.stb_pending = 1'b1; u_if.ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (u_if.progress_ucode !== 1'b0 || u_if.minx !== 8'h10 || u_if.busy_shift !== 1'b0) begin
        n_bad++;
        $display("FAIL bus_wait cycle %0d got prog=%b minx=%h busy=%b want 0 10 0",
                 i, u_if.progress_ucode, u_if.minx, u_if.busy_shift);
      end
      step();
    end
    u_if.ack_i = 1'b1;
    #2;
    n_cmp++;
    if (u_if.progress_ucode !== 1'b1 || u_if.minx !== 8'h70) begin
      n_bad++;
      $display("FAIL bus_ack got prog=%b minx=%h want 1 70", u_if.progress_ucode, u_if.minx);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    clear_inputs();
    u_if.rinx = 8'h12;
    step();
    u_if.shcnt_load = 1'b1; u_if.shamt = 5'd8;
    step();
    u_if.shcnt_load = 1'b0;
    step();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (u_if.busy_shift !== 1'b1 || u_if.minx !== 8'h12) begin
      n_bad++;
      $display("FAIL mid_shift_busy got busy=%b minx=%h want 1 12", u_if.busy_shift, u_if.minx);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_cmp++;
      if (u_if.minx !== 8'h01 || u_if.busy_shift !== 1'b0 || u_if.progress_ucode !== 1'b1) begin
        n_bad++;
        $display("FAIL shift_abort cycle %0d got minx=%h busy=%b prog=%b want 01 0 1",
                 i, u_if.minx, u_if.busy_shift, u_if.progress_ucode);
      end
      step();
    end
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h12) begin
      n_bad++;
      $display("FAIL shift_abort_exit got minx=%h want 12", u_if.minx);
    end
    step();
    u_if.stb_pending = 1'b1; u_if.ack_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    n_cmp++;
    if (u_if.minx !== 8'h01 || u_if.progress_ucode !== 1'b1) begin
      n_bad++;
      $display("FAIL bus_abort got minx=%h prog=%b want 01 1", u_if.minx, u_if.progress_ucode);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_branch();
    test_dispatch();
    test_shift();
    test_bus_wait();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
